// File: rtl/risc_spm_core.sv
// risc_spm_core: multi-cycle stored-program CPU; host loads memory via ext_* while stopped, pulses start, polls halted/err/zflag/cflag
module risc_spm_core #(
  parameter int WORD_W = 8,
  parameter int REG_CNT = 4,
  parameter int MEM_DEPTH = 2 ** WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ext_we,
  input  logic [WORD_W-1:0] ext_addr,
  input  logic [WORD_W-1:0] ext_wdata,
  output logic [WORD_W-1:0] ext_rdata,
  output logic              running,
  output logic              halted,
  output logic              err,
  output logic              zflag,
  output logic              cflag
);
  localparam int RSEL_W = $clog2(REG_CNT);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [WORD_W-1:0] PC_LAST = WORD_W'(MEM_DEPTH - 1);
  typedef enum logic [3:0] {IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT} state_t;
  state_t state;
  logic [WORD_W-1:0] pc, ar, ir, y, a, b, mem_q, pc_inc;
  logic [WORD_W-1:0] r [REG_CNT];
  logic [WORD_W-1:0] mem [MEM_DEPTH];
  logic [WORD_W:0] alu;
  logic [3:0] op;
  logic [RSEL_W-1:0] src, dst;
  assign op = ir[WORD_W-1 -: 4];
  assign src = ir[2*RSEL_W-1 -: RSEL_W];
  assign dst = ir[RSEL_W-1:0];
  assign mem_q = mem[ar[AW-1:0]];
  assign ext_rdata = mem[ext_addr[AW-1:0]];
  assign pc_inc = (pc == PC_LAST) ? '0 : pc + 1'b1;
  assign running = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);
  assign a = r[dst];
  assign b = (state == EX1) ? y : r[src];
  always_comb begin
    alu = '0;
    case (op)
      4'd1:  alu = {1'b0, a} + {1'b0, b};
      4'd2:  alu = {1'b0, a} - {1'b0, b};
      4'd3:  alu = {1'b0, a & b};
      4'd4:  alu = {1'b0, ~b};
      4'd9:  alu = {1'b0, a | b};
      4'd10: alu = {1'b0, a ^ b};
      4'd11: alu = {b, 1'b0};
      4'd12: alu = {b[0], 1'b0, b[WORD_W-1:1]};
      default: alu = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      ar <= '0;
      ir <= '0;
      y <= '0;
      r <= '{default: '0};
      zflag <= 1'b0;
      cflag <= 1'b0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          state <= FET1;
          pc <= '0;
          zflag <= 1'b0;
          cflag <= 1'b0;
          err <= 1'b0;
        end
        FET1: begin
          ar <= pc;
          state <= FET2;
        end
        FET2: begin
          ir <= mem_q;
          pc <= pc_inc;
          state <= DEC;
        end
        DEC: case (op)
          4'd0: state <= FET1;
          4'd1, 4'd2, 4'd3, 4'd9, 4'd10: begin
            y <= r[src];
            state <= EX1;
          end
          4'd4, 4'd11, 4'd12: begin
            r[dst] <= alu[WORD_W-1:0];
            zflag <= (alu[WORD_W-1:0] == '0);
            cflag <= alu[WORD_W];
            state <= FET1;
          end
          4'd5: begin
            ar <= pc;
            state <= RD1;
          end
          4'd6: begin
            ar <= pc;
            state <= WR1;
          end
          4'd7: begin
            ar <= pc;
            state <= BR1;
          end
          4'd8, 4'd13: if ((op == 4'd8) ? zflag : cflag) begin
            ar <= pc;
            state <= BR1;
          end else begin
            pc <= pc_inc;
            state <= FET1;
          end
          4'd14: state <= HALT;
          default: begin
            err <= 1'b1;
            state <= HALT;
          end
        endcase
        EX1: begin
          r[dst] <= alu[WORD_W-1:0];
          zflag <= (alu[WORD_W-1:0] == '0);
          cflag <= alu[WORD_W];
          state <= FET1;
        end
        RD1, WR1: begin
          ar <= mem_q;
          pc <= pc_inc;
          state <= (state == RD1) ? RD2 : WR2;
        end
        RD2: begin
          r[dst] <= mem_q;
          state <= FET1;
        end
        WR2: state <= FET1;
        BR1: begin
          ar <= mem_q;
          state <= BR2;
        end
        BR2: begin
          pc <= ar;
          state <= FET1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (state == WR2) mem[ar[AW-1:0]] <= r[src];
    else if (ext_we && !running) mem[ext_addr[AW-1:0]] <= ext_wdata;
  end
endmodule

// File: tb/tb_risc_spm_core.sv
// tb_risc_spm_core: scoreboard bench for risc_spm_core at default and 12-bit/8-register parameters
module tb_risc_spm_core;
  logic clk = 1'b0;
  logic rst, start, ext_we, running, halted, err, zflag, cflag;
  logic [7:0] ext_addr, ext_wdata, ext_rdata;
  logic start2, ext_we2, running2, halted2, err2, zflag2, cflag2;
  logic [11:0] ext_addr2, ext_wdata2, ext_rdata2;
  typedef struct {string n; logic [31:0] v;} exp_t;
  exp_t sb[$];
  logic [31:0] obs[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  risc_spm_core dut (
    .clk(clk), .rst(rst), .start(start), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .running(running), .halted(halted),
    .err(err), .zflag(zflag), .cflag(cflag)
  );

  risc_spm_core #(.WORD_W(12), .REG_CNT(8), .MEM_DEPTH(4096)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ext_we(ext_we2), .ext_addr(ext_addr2),
    .ext_wdata(ext_wdata2), .ext_rdata(ext_rdata2), .running(running2), .halted(halted2),
    .err(err2), .zflag(zflag2), .cflag(cflag2)
  );

  task automatic push_exp(input string n, input logic [31:0] v);
    exp_t e;
    e.n = n;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ext_we = 1'b1;
    ext_addr = a;
    ext_wdata = d;
    @(negedge clk);
    ext_we = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    ext_addr = a;
    #1 d = ext_rdata;
  endtask

  task automatic run(output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (running && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic load2(input logic [11:0] a, input logic [11:0] d);
    @(negedge clk);
    ext_we2 = 1'b1;
    ext_addr2 = a;
    ext_wdata2 = d;
    @(negedge clk);
    ext_we2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push_exp("rst_running", 0); push_exp("rst_halted", 0); push_exp("rst_err", 0);
    push_exp("rst_z", 0); push_exp("rst_c", 0); push_exp("rst_running2", 0);
    obs.push_back(32'(running)); obs.push_back(32'(halted)); obs.push_back(32'(err));
    obs.push_back(32'(zflag)); obs.push_back(32'(cflag)); obs.push_back(32'(running2));
    rst = 1'b0;
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_program;
    logic [7:0] p[8] = '{8'h50, 8'h10, 8'h51, 8'h11, 8'h14, 8'h60, 8'h20, 8'hE0};
    logic [8:0] s = {1'b0, 8'h05} + {1'b0, 8'hFB};
    logic [7:0] d;
    int cyc;
    foreach (p[i]) load(8'(i), p[i]);
    load(8'h10, 8'h05); load(8'h11, 8'hFB); load(8'h20, 8'hAA);
    push_exp("prog_halted", 1); push_exp("prog_err", 0); push_exp("prog_cycles", 22);
    push_exp("prog_mem20", 32'(s[7:0])); push_exp("prog_z", 32'(s[7:0] == 8'h00)); push_exp("prog_c", 32'(s[8]));
    run(cyc);
    peek(8'h20, d);
    obs.push_back(32'(halted)); obs.push_back(32'(err)); obs.push_back(32'(cyc));
    obs.push_back(32'(d)); obs.push_back(32'(zflag)); obs.push_back(32'(cflag));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_sub_shr;
    logic [7:0] p[8] = '{8'h50, 8'h10, 8'h51, 8'h11, 8'h24, 8'h60, 8'h30, 8'hE0};
    logic [7:0] q[6] = '{8'h52, 8'h12, 8'hCB, 8'h6C, 8'h31, 8'hE0};
    logic [8:0] s = {1'b0, 8'd3} - {1'b0, 8'd5};
    logic [7:0] sh = 8'h01 >> 1;
    logic [7:0] d;
    int cyc;
    foreach (p[i]) load(8'(i), p[i]);
    load(8'h10, 8'h03); load(8'h11, 8'h05); load(8'h30, 8'h00);
    push_exp("sub_mem30", 32'(s[7:0])); push_exp("sub_z", 32'(s[7:0] == 8'h00));
    push_exp("sub_c", 32'(s[8])); push_exp("sub_cycles", 22);
    run(cyc);
    peek(8'h30, d);
    obs.push_back(32'(d)); obs.push_back(32'(zflag)); obs.push_back(32'(cflag)); obs.push_back(32'(cyc));
    foreach (q[i]) load(8'(i), q[i]);
    load(8'h12, 8'h01); load(8'h31, 8'hAA);
    push_exp("shr_mem31", 32'(sh)); push_exp("shr_z", 32'(sh == 8'h00));
    push_exp("shr_c", 1); push_exp("shr_cycles", 16);
    run(cyc);
    peek(8'h31, d);
    obs.push_back(32'(d)); obs.push_back(32'(zflag)); obs.push_back(32'(cflag)); obs.push_back(32'(cyc));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_brz;
    logic [7:0] p[4] = '{8'hA0, 8'h80, 8'h10, 8'hF0};
    logic [7:0] q[3] = '{8'h80, 8'h10, 8'hE0};
    int cyc;
    foreach (p[i]) load(8'(i), p[i]);
    load(8'h10, 8'hE0);
    push_exp("brz_taken_cycles", 12); push_exp("brz_taken_err", 0);
    push_exp("brz_taken_halted", 1); push_exp("brz_taken_z", 1);
    run(cyc);
    obs.push_back(32'(cyc)); obs.push_back(32'(err)); obs.push_back(32'(halted)); obs.push_back(32'(zflag));
    foreach (q[i]) load(8'(i), q[i]);
    load(8'h10, 8'hF0);
    push_exp("brz_skip_cycles", 6); push_exp("brz_skip_err", 0); push_exp("brz_skip_halted", 1);
    run(cyc);
    obs.push_back(32'(cyc)); obs.push_back(32'(err)); obs.push_back(32'(halted));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_illegal;
    int cyc;
    load(8'h00, 8'hF0);
    push_exp("ill_halted", 1); push_exp("ill_err", 1); push_exp("ill_cycles", 3);
    run(cyc);
    obs.push_back(32'(halted)); obs.push_back(32'(err)); obs.push_back(32'(cyc));
    load(8'h00, 8'hE0);
    push_exp("restart_halted", 1); push_exp("restart_err", 0); push_exp("restart_cycles", 3);
    run(cyc);
    obs.push_back(32'(halted)); obs.push_back(32'(err)); obs.push_back(32'(cyc));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_ext_we_running;
    logic [7:0] p[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE0};
    logic [7:0] d;
    int cyc = 0;
    foreach (p[i]) load(8'(i), p[i]);
    load(8'h40, 8'h11);
    push_exp("extwe_mem40", 32'h11); push_exp("extwe_halted", 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ext_we = 1'b1;
    ext_addr = 8'h40;
    ext_wdata = 8'h99;
    repeat (3) @(negedge clk);
    ext_we = 1'b0;
    while (running && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    peek(8'h40, d);
    obs.push_back(32'(d)); obs.push_back(32'(halted));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_rst_wr2;
    logic [7:0] p[5] = '{8'h50, 8'h51, 8'h60, 8'h50, 8'hE0};
    logic [7:0] q[3] = '{8'h60, 8'h52, 8'hE0};
    logic [7:0] d;
    int cyc;
    foreach (p[i]) load(8'(i), p[i]);
    load(8'h51, 8'h33); load(8'h50, 8'h77);
    push_exp("wr2_mem50", 32'h77); push_exp("wr2_running", 0); push_exp("wr2_halted", 0);
    push_exp("wr2_err", 0); push_exp("wr2_z", 0); push_exp("wr2_c", 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    peek(8'h50, d);
    obs.push_back(32'(d)); obs.push_back(32'(running)); obs.push_back(32'(halted));
    obs.push_back(32'(err)); obs.push_back(32'(zflag)); obs.push_back(32'(cflag));
    @(negedge clk);
    rst = 1'b0;
    foreach (q[i]) load(8'(i), q[i]);
    load(8'h52, 8'h5A);
    push_exp("rst_r0_cleared", 0);
    run(cyc);
    peek(8'h52, d);
    obs.push_back(32'(d));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  task automatic test_param_sweep;
    logic [11:0] p[8] = '{12'h507, 12'h100, 12'h506, 12'h101, 12'h137, 12'h638, 12'h200, 12'hE00};
    logic [12:0] s = {1'b0, 12'hFFF} + {1'b0, 12'h001};
    int cyc = 0;
    foreach (p[i]) load2(12'(i), p[i]);
    load2(12'h100, 12'hFFF); load2(12'h101, 12'h001); load2(12'h200, 12'hABC);
    push_exp("w12_mem200", 32'(s[11:0])); push_exp("w12_z", 32'(s[11:0] == 12'h000));
    push_exp("w12_c", 32'(s[12])); push_exp("w12_halted", 1); push_exp("w12_err", 0);
    push_exp("w12_cycles", 22);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (running2 && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    ext_addr2 = 12'h200;
    #1;
    obs.push_back(32'(ext_rdata2)); obs.push_back(32'(zflag2)); obs.push_back(32'(cflag2));
    obs.push_back(32'(halted2)); obs.push_back(32'(err2)); obs.push_back(32'(cyc));
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      logic [31:0] o = obs.pop_front();
      total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %0h expected %0h", e.n, o, e.v); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ext_we = 1'b0;
    ext_addr = '0;
    ext_wdata = '0;
    start2 = 1'b0;
    ext_we2 = 1'b0;
    ext_addr2 = '0;
    ext_wdata2 = '0;
    test_reset;
    test_program;
    test_sub_shr;
    test_brz;
    test_illegal;
    test_ext_we_running;
    test_rst_wr2;
    test_param_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
